// File: rtl/fc_weight_server_if.sv
// fc_weight_server_if
//   Request/response bus between an FC layer controller (master) and the
//   weight server (slave).
//   req_valid/req_ready/req_addr       : set-address request handshake
//   weight_set/weight_valid/weight_ready : packed weight-set response handshake
interface fc_weight_server_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int READ_SIZE  = 256
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [READ_SIZE-1:0]  weight_set;
  logic                  weight_valid;
  logic                  weight_ready;

  modport master (
    output req_valid, req_addr, weight_ready,
    input  req_ready, weight_set, weight_valid
  );

  modport slave (
    input  req_valid, req_addr, weight_ready,
    output req_ready, weight_set, weight_valid
  );
endinterface

// File: rtl/fc_weight_server.sv
// fc_weight_server
//   Accepts one weight-set address, reads READ_SET consecutive words from a
//   single-port weight SRAM and packs them into one wide word presented with
//   a valid/ready handshake.
//
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     bus         : fc_weight_server_if.slave (request + packed response)
//     mem_rd_en   : registered SRAM read strobe
//     mem_addr    : registered SRAM word address (set*READ_SET + lane)
//     mem_rdata   : SRAM data, valid the cycle after the SRAM samples mem_rd_en
//     busy        : high whenever the block is not IDLE
//
//   Optional feature: define FC_WSRV_ZERO_OOR_EN to answer requests with
//   req_addr >= NUM_SETS with an all-zero set and no SRAM reads.
//
//   state | meaning
//   IDLE  | ready for a request
//   FETCH | issuing SRAM reads, one per cycle
//   DRAIN | reads done, waiting for the last words to return
//   HOLD  | weight_set complete, waiting for consumer handshake
module fc_weight_server #(
  parameter int DATA_WIDTH     = 16,
  parameter int READ_SET       = 16,
  parameter int READ_SIZE      = DATA_WIDTH * READ_SET,
  parameter int ADDR_WIDTH     = 12,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int NUM_SETS       = 3000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fc_weight_server_if.slave         bus,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);

  localparam int LANE_W = $clog2(READ_SET);
  localparam int CNT_W  = LANE_W + 1;

`ifdef FC_WSRV_ZERO_OOR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      req_ready_q;
  logic                      busy_q;
  logic                      rd_en_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]          rd_cnt_q;
  logic [CNT_W-1:0]          wr_cnt_q;
  logic                      cap_q;
  logic [READ_SIZE-1:0]      set_q;
  logic                      wvalid_q;

  logic [MEM_ADDR_WIDTH-1:0] base_d;
  logic [31:0]               addr_ext_d;
  logic                      oor_d;

  assign base_d     = MEM_ADDR_WIDTH'(bus.req_addr) << LANE_W;
  assign addr_ext_d = 32'(bus.req_addr);
  // Without the range-check feature OOR_EN is constant 0, so every address
  // is fetched normally.
  assign oor_d      = OOR_EN && (addr_ext_d >= 32'(NUM_SETS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      cap_q       <= 1'b0;
      set_q       <= '0;
      wvalid_q    <= 1'b0;
    end else begin
      // Data for a strobe issued in cycle n arrives for the edge ending
      // cycle n+1, so the capture enable is the strobe delayed by one.
      cap_q <= rd_en_q;
      if (cap_q) begin
        for (int i = 0; i < READ_SET; i++) begin
          if (wr_cnt_q == CNT_W'(i)) set_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        end
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            base_q      <= base_d;
            wr_cnt_q    <= '0;
            if (oor_d) begin
              set_q   <= '0;
              state_q <= S_HOLD;
            end else begin
              // Lane 0 read is issued straight from the accept edge.
              rd_en_q  <= 1'b1;
              addr_q   <= base_d;
              rd_cnt_q <= CNT_W'(1);
              state_q  <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (rd_cnt_q == CNT_W'(READ_SET)) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q   <= base_q + MEM_ADDR_WIDTH'(rd_cnt_q);
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (cap_q && (wr_cnt_q == CNT_W'(READ_SET - 1))) begin
            wvalid_q <= 1'b1;
            state_q  <= S_HOLD;
          end
        end

        S_HOLD: begin
          // Entry without valid only happens on the out-of-range path,
          // which presents its zero set one cycle after accept.
          if (!wvalid_q) begin
            wvalid_q <= 1'b1;
          end else if (bus.weight_ready) begin
            wvalid_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.weight_set   = set_q;
  assign bus.weight_valid = wvalid_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_addr         = addr_q;
  assign busy             = busy_q;

endmodule
